ring_osc_meter: RTL

- Multi-channel ring-oscillator frequency meter; the parametrised successor of the single-channel oscillator/gated-counter pair.
- Enables NCH on-chip oscillators, settles them, and counts the rising edges of each over an exact GATE_CYCLES-clock window.
- Latches per-channel results and overflow flags, then presents one selected channel to the 7-segment scan display or LED path.
- Supports single-shot and continuous measurement.

---
 rtl/ring_osc_meter_pkg.sv | 18 +
 rtl/ring_osc_meter_if.sv | 27 ++
 rtl/ring_osc_meter_osc_edge_counter.sv | 58 +++++
 rtl/ring_osc_meter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ring_osc_meter_pkg.sv
// Shared state encoding and default sizing for the ring-oscillator frequency meter.
package ring_osc_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_LATCH  = 2'd3
  } state_e;

  localparam int unsigned DEF_NCH           = 4;
  localparam int unsigned DEF_CNT_W         = 16;
  localparam int unsigned DEF_GATE_W        = 20;
  localparam int unsigned DEF_GATE_CYCLES   = 50000;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;
  localparam int unsigned DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/ring_osc_meter_if.sv
// Control, oscillator and result signals of the frequency meter, grouped for the top-level port.
interface ring_osc_meter_if
  import ring_osc_meter_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W
);
  logic             start;
  logic             mode_cont;
  logic [NCH-1:0]   osc_in;
  logic [3:0]       sel;
  logic [NCH-1:0]   osc_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt_out;
  logic             ovf_out;

  modport slave (
    input  start, mode_cont, osc_in, sel,
    output osc_en, busy, done, cnt_out, ovf_out
  );

  modport master (
    output start, mode_cont, osc_in, sel,
    input  osc_en, busy, done, cnt_out, ovf_out
  );
endinterface

// File: rtl/ring_osc_meter_osc_edge_counter.sv
// One channel: synchronises an async oscillator, detects rising edges and counts them with saturation.
module osc_edge_counter
  import ring_osc_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             osc,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   rise;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc};
      prev_q <= sync_q[SYNC_STAGES-1];
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // A saturated counter holds its value; the next edge marks the overflow instead.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (cnt_clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (cnt_en && rise) begin
      if (cnt_q == {CNT_W{1'b1}}) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/ring_osc_meter.sv
// Multi-channel ring-oscillator meter: settle, gate for GATE_CYCLES clocks, latch, present one channel.
// states: IDLE osc off | SETTLE warm-up, counters held | GATE counting | LATCH copy results, clear counters
module ring_osc_meter
  import ring_osc_meter_pkg::*;
#(
  parameter int NCH           = DEF_NCH,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int GATE_W        = DEF_GATE_W,
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            clr,
  ring_osc_meter_if.slave bus
);

  localparam logic [GATE_W-1:0] GATE_LOAD   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] SETTLE_LOAD = GATE_W'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [GATE_W-1:0] timer_q, timer_d;
  logic              start_q;
  logic              done_q;
  logic              start_rise;
  logic              cnt_en, cnt_clr, latch_en;

  logic [CNT_W-1:0]  cnt_w [NCH];
  logic [NCH-1:0]    ovf_w;
  logic [CNT_W-1:0]  res_cnt_q [NCH];
  logic [NCH-1:0]    res_ovf_q;

  assign start_rise = bus.start & ~start_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      start_q <= bus.start;
      done_q  <= latch_en;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    latch_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (start_rise) begin
          state_d = ST_SETTLE;
          timer_d = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        cnt_clr = 1'b1;
        if (timer_q == '0) begin
          state_d = ST_GATE;
          timer_d = GATE_LOAD;
        end else begin
          timer_d = timer_q - GATE_W'(1);
        end
      end
      ST_GATE: begin
        cnt_en = 1'b1;
        if (timer_q == '0) begin
          state_d = ST_LATCH;
        end else begin
          timer_d = timer_q - GATE_W'(1);
        end
      end
      ST_LATCH: begin
        latch_en = 1'b1;
        cnt_clr  = 1'b1;
        if (bus.mode_cont) begin
          state_d = ST_GATE;
          timer_d = GATE_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    osc_edge_counter #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_cnt (
      .clk     (clk),
      .clr     (clr),
      .osc     (bus.osc_in[g]),
      .cnt_en  (cnt_en),
      .cnt_clr (cnt_clr),
      .cnt     (cnt_w[g]),
      .ovf     (ovf_w[g])
    );
  end

  // Results are copied on the LATCH edge, so they appear together with done.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NCH; i++) res_cnt_q[i] <= '0;
      res_ovf_q <= '0;
    end else if (latch_en) begin
      for (int i = 0; i < NCH; i++) res_cnt_q[i] <= cnt_w[i];
      res_ovf_q <= ovf_w;
    end
  end

  always_comb begin
    bus.cnt_out = '0;
    bus.ovf_out = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.sel == 4'(i)) begin
        bus.cnt_out = res_cnt_q[i];
        bus.ovf_out = res_ovf_q[i];
      end
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.osc_en = {NCH{state_q != ST_IDLE}};
  assign bus.done   = done_q;

endmodule
